// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/commit controller: allocates the tail entry on issue,
// retires the head entry in program order, and drives the register-file write port.
module rob_slot #(
  parameter int PTR_W = 3,
  parameter int IDX   = 0
) (
  input  logic [PTR_W-1:0] tail,
  input  logic [PTR_W-1:0] head,
  input  logic             accept,
  input  logic             wen,
  output logic             sel_bit,
  output logic             hit,
  output logic             stray
);
  localparam logic [PTR_W-1:0] ID = PTR_W'(IDX);

  assign sel_bit = accept && (tail == ID);
  assign hit     = wen && (head == ID);
  // A write-back strobe from any entry other than the oldest is out of order.
  assign stray   = wen && (head != ID);
endmodule

module rob_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  output logic [DEPTH-1:0]   sel,
  output logic [PTR_W-1:0]   tail,
  output logic [PTR_W-1:0]   head,
  input  logic [DEPTH-1:0]   entry_wen,
  input  logic [5*DEPTH-1:0] entry_dest,
  input  logic [32*DEPTH-1:0] entry_val,
  input  logic               flush,
  output logic               empty,
  output logic [PTR_W:0]     count,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               err
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             full;
  logic             accept;
  logic             commit;
  logic             err_set;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] stray;
  logic [4:0]       cur_dest;
  logic [31:0]      cur_val;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign issue_ready = !full && !flush;
  assign accept      = issue_valid && issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      rob_slot #(.PTR_W(PTR_W), .IDX(gi)) u_slot (
        .tail    (tail),
        .head    (head),
        .accept  (accept),
        .wen     (entry_wen[gi]),
        .sel_bit (sel[gi]),
        .hit     (hit[gi]),
        .stray   (stray[gi])
      );
    end
  endgenerate

  // Flush wins over a same-cycle commit; the head strobe is simply dropped.
  assign commit  = (|hit) && !empty && !flush;
  assign err_set = (|stray) || ((|entry_wen) && empty);

  always_comb begin
    cur_dest = '0;
    cur_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head == PTR_W'(i)) begin
        cur_dest = entry_dest[i*5 +: 5];
        cur_val  = entry_val[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (commit) head <= head + PTR_W'(1);
      if (accept) tail <= tail + PTR_W'(1);
      case ({accept, commit})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Writes to x0 retire normally but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
    end else begin
      rf_we <= commit && (cur_dest != 5'd0);
      if (commit) begin
        rf_waddr <= cur_dest;
        rf_wdata <= cur_val;
      end
      if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios plus randomized traffic
// scored against an occupancy/pointer model kept in plain integers.
module tb_rob_ctrl;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               issue_valid = 1'b0;
  logic               issue_ready;
  logic [DEPTH-1:0]   sel;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   head;
  logic [DEPTH-1:0]   entry_wen = '0;
  logic [5*DEPTH-1:0] entry_dest = '0;
  logic [32*DEPTH-1:0] entry_val = '0;
  logic               flush = 1'b0;
  logic               empty;
  logic [PTR_W:0]     count;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               err;

  int checks = 0;
  int errors = 0;

  rob_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sel(sel), .tail(tail), .head(head), .entry_wen(entry_wen),
    .entry_dest(entry_dest), .entry_val(entry_val), .flush(flush),
    .empty(empty), .count(count), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after each rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DEPTH-1:0] wen, input logic fl);
    issue_valid = iv;
    entry_wen   = wen;
    flush       = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic commit_one(input int idx, input logic [4:0] d, input logic [31:0] v);
    entry_dest[idx*5 +: 5]  = d;
    entry_val[idx*32 +: 32] = v;
    drive(1'b0, DEPTH'(1) << idx, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || issue_ready !== 1'b1) begin errors++; $display("FAIL reset_flags got empty=%b ready=%b exp 1/1", empty, issue_ready); end
    checks++; if (sel !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got sel=%h err=%b exp 00/0", sel, err); end
    // Build count=5 with a live rf write, then drop reset between edges.
    alloc_n(6);
    commit_one(0, 5'd9, 32'h1234_5678);
    checks++; if (count !== 4'd5 || rf_we !== 1'b1) begin errors++; $display("FAIL reset_setup got count=%0d rf_we=%b exp 5/1", count, rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (head !== 3'd0 || tail !== 3'd0 || count !== 4'd0) begin errors++; $display("FAIL reset_async_ptrs got h=%0d t=%0d c=%0d exp 0/0/0", head, tail, count); end
    checks++; if (empty !== 1'b1 || issue_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL reset_async_flags got empty=%b ready=%b rf_we=%b exp 1/1/0", empty, issue_ready, rf_we); end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic [7:0] exp_sel;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, '0, 1'b0);
      #1;
      exp_sel = 8'h01 << i;
      checks++; if (sel !== exp_sel) begin errors++; $display("FAIL fill_sel[%0d] got %h exp %h", i, sel, exp_sel); end
      tick();
    end
    checks++; if (count !== 4'd8 || issue_ready !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL fill_full got count=%0d ready=%b empty=%b exp 8/0/0", count, issue_ready, empty); end
    #1;
    checks++; if (sel !== 8'h00) begin errors++; $display("FAIL fill_ninth_sel got %h exp 00", sel); end
    tick();
    checks++; if (tail !== 3'd0 || count !== 4'd8) begin errors++; $display("FAIL fill_ninth_hold got t=%0d c=%0d exp 0/8", tail, count); end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_commit();
    do_reset();
    alloc_n(2);
    commit_one(0, 5'd5, 32'hDEAD_BEEF);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL commit_rf got we=%b a=%0d d=%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    checks++; if (head !== 3'd1 || count !== 4'd1) begin errors++; $display("FAIL commit_ptr got h=%0d c=%0d exp 1/1", head, count); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL commit_one_shot got rf_we=%b exp 0", rf_we); end
    commit_one(1, 5'd0, 32'hCAFE_0000);
    checks++; if (rf_we !== 1'b0 || head !== 3'd2 || count !== 4'd0) begin errors++; $display("FAIL commit_x0 got we=%b h=%0d c=%0d exp 0/2/0", rf_we, head, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_n(8);
    for (int i = 0; i < 7; i++) commit_one(i, 5'(i + 1), 32'(i));
    alloc_n(3);
    checks++; if (head !== 3'd7 || tail !== 3'd3 || count !== 4'd4) begin errors++; $display("FAIL wrap_setup got h=%0d t=%0d c=%0d exp 7/3/4", head, tail, count); end
    entry_dest[7*5 +: 5]  = 5'd31;
    entry_val[7*32 +: 32] = 32'hA5A5_0007;
    drive(1'b1, 8'h80, 1'b0);
    #1;
    checks++; if (sel !== 8'h08) begin errors++; $display("FAIL wrap_sel got %h exp 08", sel); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (head !== 3'd0 || tail !== 3'd4 || count !== 4'd4) begin errors++; $display("FAIL wrap_ptrs got h=%0d t=%0d c=%0d exp 0/4/4", head, tail, count); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'hA5A5_0007) begin errors++; $display("FAIL wrap_rf got we=%b a=%0d d=%h exp 1/31/a5a50007", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(6);
    entry_dest[0 +: 5] = 5'd3;
    drive(1'b1, 8'h01, 1'b1);
    #1;
    checks++; if (sel !== 8'h00 || issue_ready !== 1'b0) begin errors++; $display("FAIL flush_comb got sel=%h ready=%b exp 00/0", sel, issue_ready); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (head !== 3'd0 || tail !== 3'd0 || count !== 4'd0) begin errors++; $display("FAIL flush_ptrs got h=%0d t=%0d c=%0d exp 0/0/0", head, tail, count); end
    checks++; if (rf_we !== 1'b0 || empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL flush_flags got we=%b empty=%b err=%b exp 0/1/0", rf_we, empty, err); end
  endtask

  // Randomized traffic against a model of occupancy as integer pointers mod DEPTH.
  task automatic test_random();
    int m_head, m_tail, m_cnt, m_waddr;
    logic m_we, iv, fl, acc, com, exp_ready;
    logic [31:0] m_wdata;
    logic [7:0] wen, exp_sel;
    do_reset();
    m_head = 0; m_tail = 0; m_cnt = 0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_dest[i*5 +: 5]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        entry_val[i*32 +: 32] = $urandom;
      end
      iv  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      wen = (m_cnt > 0 && $urandom_range(0, 1) == 1) ? (8'h01 << m_head) : 8'h00;
      drive(iv, wen, fl);
      #1;
      exp_ready = (m_cnt != DEPTH) && !fl;
      acc       = iv && exp_ready;
      exp_sel   = acc ? (8'h01 << m_tail) : 8'h00;
      checks++; if (issue_ready !== exp_ready || sel !== exp_sel) begin errors++; $display("FAIL rand_alloc[%0d] got ready=%b sel=%h exp %b/%h", n, issue_ready, sel, exp_ready, exp_sel); end
      com = wen[m_head] && m_cnt != 0 && !fl;
      m_we = 1'b0;
      m_waddr = 0;
      m_wdata = '0;
      if (fl) begin
        m_head = 0; m_tail = 0; m_cnt = 0;
      end else begin
        if (com) begin
          m_waddr = int'(entry_dest[m_head*5 +: 5]);
          m_wdata = entry_val[m_head*32 +: 32];
          m_we    = (m_waddr != 0);
          m_head  = (m_head + 1) % DEPTH;
          m_cnt   = m_cnt - 1;
        end
        if (acc) begin
          m_tail = (m_tail + 1) % DEPTH;
          m_cnt  = m_cnt + 1;
        end
      end
      tick();
      checks++; if (int'(head) != m_head || int'(tail) != m_tail || int'(count) != m_cnt) begin errors++; $display("FAIL rand_ptrs[%0d] got h=%0d t=%0d c=%0d exp %0d/%0d/%0d", n, head, tail, count, m_head, m_tail, m_cnt); end
      checks++; if (rf_we !== m_we || empty !== (m_cnt == 0) || err !== 1'b0) begin errors++; $display("FAIL rand_flags[%0d] got we=%b empty=%b err=%b exp %b/%b/0", n, rf_we, empty, err, m_we, (m_cnt == 0)); end
      if (m_we) begin
        checks++; if (int'(rf_waddr) != m_waddr || rf_wdata !== m_wdata) begin errors++; $display("FAIL rand_rf[%0d] got a=%0d d=%h exp %0d/%h", n, rf_waddr, rf_wdata, m_waddr, m_wdata); end
      end
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_error();
    do_reset();
    alloc_n(3);
    commit_one(0, 5'd4, 32'h1);
    drive(1'b0, 8'h08, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (err !== 1'b1 || head !== 3'd1 || count !== 4'd2) begin errors++; $display("FAIL err_stray got err=%b h=%0d c=%0d exp 1/1/2", err, head, count); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL err_no_write got rf_we=%b exp 0", rf_we); end
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 8'h01, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (err !== 1'b1 || head !== 3'd0 || count !== 4'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL err_empty got err=%b h=%0d c=%0d we=%b exp 1/0/0/0", err, head, count, rf_we); end
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_flush got err=%b exp 1", err); end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset got err=%b exp 0", err); end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_commit();
    test_wrap();
    test_flush();
    test_random();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000ns");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Pointer and commit controller for the 8-entry reorder buffer. Upstream, it accepts instructions from the issue stage and raises a one-hot `sel` to the tail entry. Downstream, it watches each entry's `wen`, retires the entry at `head` in program order, and drives the architectural register-file write port. It also owns occupancy (full/empty) and flush.

## Interface

Parameters:
- `DEPTH`, 8: number of reorder buffer entries. Must be a power of two.
- `PTR_W`, 3: pointer width, log2(DEPTH).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `issue_valid` in 1: issue stage presents an instruction this cycle.
- `issue_ready` out 1: an entry is free; the instruction is accepted when `issue_valid && issue_ready`.
- `sel` out DEPTH: one-hot allocate strobe to the entries; bit `tail` is set on an accepted issue.
- `tail` out PTR_W: index of the next entry to allocate.
- `head` out PTR_W: index of the oldest entry; feeds every entry's `head` input.
- `entry_wen` in DEPTH: concatenated `wen` outputs of the entries.
- `entry_dest` in 5*DEPTH: concatenated `dest`; entry i occupies bits [5i+4:5i].
- `entry_val` in 32*DEPTH: concatenated result values; entry i occupies bits [32i+31:32i].
- `flush` in 1: discard all in-flight entries.
- `empty` out 1: count == 0.
- `count` out PTR_W+1: occupied entries, 0..DEPTH.
- `rf_we` out 1: register-file write enable (registered).
- `rf_waddr` out 5: register-file write address (registered).
- `rf_wdata` out 32: register-file write data (registered).
- `err` out 1: sticky protocol-error flag.

## Operation

- **Registers and reset.**
  - State registers: `head`, `tail`, `count`, `rf_we`, `rf_waddr`, `rf_wdata`, `err`.
  - All of them reset asynchronously to 0 on `rst_n` low, regardless of clock.
  - Outputs at reset: `issue_ready`=1, `empty`=1, `sel`=0.
- **Allocate.**
  - `issue_ready = (count != DEPTH)`, combinational.
  - `sel = (issue_valid && issue_ready) ? (1 << tail) : 0`, combinational, so the entry samples it on the same edge.
  - On acceptance, `tail` increments modulo DEPTH (7 wraps to 0).
- **Commit.**
  - Commit occurs when `entry_wen[head]` is 1 and `count != 0`.
  - On commit, `head` increments modulo DEPTH.
  - Next cycle: `rf_waddr = entry_dest[head]` and `rf_wdata = entry_val[head]`, both sampled from the pre-increment `head`.
  - Next cycle: `rf_we` is 1 unless `rf_waddr` is 0. A write to x0 is suppressed, but the entry still retires and `head` still advances.
- **Count.**
  - +1 on allocate only; −1 on commit only.
  - Allocate and commit in the same cycle leave `count` unchanged; both pointers move.
  - Allocate in the same cycle as a commit while full is not permitted, because `issue_ready` is already 0. The freed slot becomes visible the following cycle.
- **Flush.**
  - Synchronous; takes priority over allocate and commit in the same cycle.
  - Sets `head`, `tail` and `count` to 0.
  - Forces `sel` to 0 and `issue_ready` to 0 during the flush cycle.
  - Forces `rf_we` to 0 on the next cycle.
  - Does not clear `err`.
- **Error.**
  - `err` sets, and stays set until reset, in two cases: any `entry_wen[i]` with i != `head`, or any `entry_wen` bit while `count == 0`.
  - The offending strobe is otherwise ignored; no pointer moves.
- **States.** There is no explicit FSM beyond occupancy: EMPTY (count 0), PARTIAL, and FULL (count DEPTH). Transitions follow the count rules above.

## Timing

- Allocate: `sel` asserts in the same cycle as `issue_valid`. `tail` and `count` update at the next rising edge.
- Commit latency: `entry_wen[head]` high in cycle N gives `rf_we`/`rf_waddr`/`rf_wdata` valid in cycle N+1, for exactly one cycle per commit.
- Throughput: one allocate and one commit per cycle. Back-to-back commits require `entry_wen` of consecutive entries in consecutive cycles.
- `head` changes at the edge ending cycle N. Entries compare against the new `head` from cycle N+1 onward.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). Operation resumes from EMPTY on the first edge after `rst_n` rises.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with count=5 → `head`=`tail`=`count`=0, `empty`=1, `issue_ready`=1, `rf_we`=0 with no clock edge required.
- **Fill to full:** 8 consecutive `issue_valid` → `sel` = 0x01, 0x02, …, 0x80; `count`=8; `issue_ready`=0. A 9th `issue_valid` produces `sel`=0 and `tail` stays 0.
- **In-order commit:**
  - Setup: entry 0 holds dest=5 and val=0xDEADBEEF; `entry_wen[0]` pulses while `head`=0.
  - Expected next cycle: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `head`=1, `count`−1.
  - A commit with dest=0 gives `rf_we`=0 while `head` still advances.
- **Simultaneous allocate + commit at wrap:**
  - Setup: `head`=7, `tail`=3, count=4, with `issue_valid` and `entry_wen[7]` in the same cycle.
  - Expected: `head`=0, `tail`=4, count=4, `sel`=0x08.
- **Flush:** with count=6, assert `flush` together with `issue_valid` and `entry_wen[head]` → `sel`=0; next cycle `head`=`tail`=`count`=0 and `rf_we`=0.
- **Protocol error:**
  - `entry_wen[3]` while `head`=1 → `err`=1 and `head` unchanged.
  - `entry_wen[0]` while empty → `err` stays 1.
  - A subsequent flush leaves `err`=1.
